// File: rtl/ysyx_24080006_pkg.sv
// Shared CSR names, trap FSM encodings, cause codes and mstatus bit helpers
// for the trap sequencer and its priority encoder.
package ysyx_24080006_pkg;

  typedef enum logic [2:0] {
    CSR_NONE    = 3'd0,
    CSR_MSTATUS = 3'd1,
    CSR_MTVEC   = 3'd2,
    CSR_MEPC    = 3'd3,
    CSR_MCAUSE  = 3'd4,
    CSR_MTVAL   = 3'd5,
    CSR_MIE     = 3'd6
  } csr_name_e;

  typedef logic [2:0] trap_state_e;
  localparam trap_state_e ST_IDLE        = 3'd0;
  localparam trap_state_e ST_SAVE_EPC    = 3'd1;
  localparam trap_state_e ST_SAVE_CAUSE  = 3'd2;
  localparam trap_state_e ST_SAVE_TVAL   = 3'd3;
  localparam trap_state_e ST_SAVE_STATUS = 3'd4;
  localparam trap_state_e ST_RESTORE     = 3'd5;
  localparam trap_state_e ST_REDIRECT    = 3'd6;

  localparam logic [31:0] EXC_IF_MISALIGN = 32'd0;
  localparam logic [31:0] EXC_ILLEGAL     = 32'd2;
  localparam logic [31:0] EXC_EBREAK      = 32'd3;
  localparam logic [31:0] EXC_LD_MISALIGN = 32'd4;
  localparam logic [31:0] EXC_ST_MISALIGN = 32'd6;
  localparam logic [31:0] EXC_ECALL       = 32'd11;
  localparam logic [31:0] IRQ_MTIMER      = 32'h8000_0007;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MTIE       = 7;

  // Context captured at accept and carried through the write sequence.
  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] tval;
    logic [31:0] target;
    logic        is_irq;
  } trap_ctx_t;

  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] trap_vector(input logic [31:0] mtvec,
                                              input logic [4:0]  code,
                                              input logic        vec_irq);
    logic [31:0] base;
    logic [31:0] r;
    base = {mtvec[31:2], 2'b00};
    r    = base;
    if (vec_irq && (mtvec[1:0] == 2'b01)) begin
      r = base + {25'd0, code, 2'b00};
    end
    return r;
  endfunction

endpackage

// File: rtl/ysyx_24080006_trap_prio.sv
// Combinational event selector: exceptions beat mret, mret beats the timer
// interrupt; yields the event class and its mcause value. Zero latency.
module ysyx_24080006_trap_prio
  import ysyx_24080006_pkg::*;
(
  input  logic [5:0]  trap_exc,
  input  logic        trap_mret,
  input  logic        irq_take,
  output logic        is_exc,
  output logic        is_irq,
  output logic        is_mret,
  output logic [31:0] cause
);

  // trap_exc = {st_misalign, ld_misalign, ecall, ebreak, illegal, if_misalign}
  always_comb begin
    is_exc  = |trap_exc;
    is_mret = !is_exc && trap_mret;
    is_irq  = !is_exc && !trap_mret && irq_take;
    cause   = '0;
    if (trap_exc[0]) begin
      cause = EXC_IF_MISALIGN;
    end else if (trap_exc[1]) begin
      cause = EXC_ILLEGAL;
    end else if (trap_exc[2]) begin
      cause = EXC_EBREAK;
    end else if (trap_exc[3]) begin
      cause = EXC_ECALL;
    end else if (trap_exc[4]) begin
      cause = EXC_LD_MISALIGN;
    end else if (trap_exc[5]) begin
      cause = EXC_ST_MISALIGN;
    end else if (is_irq) begin
      cause = IRQ_MTIMER;
    end
  end

endmodule

// File: rtl/ysyx_24080006_trap_ctrl.sv
// Trap sequencer: one CSR write per cycle (4 for a trap, 3 without mtval, 1 for
// mret), then a PC redirect held until redirect_ready; busy stalls the pipe.
module ysyx_24080006_trap_ctrl
  import ysyx_24080006_pkg::*;
#(
  parameter logic VECTORED_EN = 1'b1,
  parameter logic TVAL_EN     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trap_valid,
  output logic        trap_ready,
  input  logic [5:0]  trap_exc,
  input  logic        trap_mret,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_npc,
  input  logic [31:0] trap_tval,
  input  logic        irq_ok,
  input  logic        irq_timer,
  input  logic [31:0] csr_mstatus,
  input  logic [31:0] csr_mie,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        csr_we,
  output csr_name_e   csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        busy
);

  trap_state_e state;
  trap_state_e state_nxt;
  trap_ctx_t   ctx;

  logic        irq_take;
  logic        is_exc;
  logic        is_irq;
  logic        is_mret;
  logic [31:0] sel_cause;
  logic        accept;
  logic        take;
  logic        unused_mie;

  assign unused_mie = ^{csr_mie[31:MIE_MTIE+1], csr_mie[MIE_MTIE-1:0]};

  // irq_timer is level-sensitive and only looked at in the accept cycle.
  assign irq_take = trap_valid & irq_ok & irq_timer
                  & csr_mstatus[MSTATUS_MIE] & csr_mie[MIE_MTIE];

  ysyx_24080006_trap_prio u_prio (
    .trap_exc  (trap_exc),
    .trap_mret (trap_mret),
    .irq_take  (irq_take),
    .is_exc    (is_exc),
    .is_irq    (is_irq),
    .is_mret   (is_mret),
    .cause     (sel_cause)
  );

  assign trap_ready     = (state == ST_IDLE);
  assign accept         = trap_valid & trap_ready;
  // A commit with nothing to take is accepted silently: no flush, no sequence.
  assign take           = accept & (is_exc | is_irq | is_mret);
  assign flush          = take;
  assign busy           = (state != ST_IDLE);
  assign redirect_valid = (state == ST_REDIRECT);
  assign redirect_pc    = redirect_valid ? ctx.target : 32'd0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (take) begin
          state_nxt = is_mret ? ST_RESTORE : ST_SAVE_EPC;
        end
      end
      ST_SAVE_EPC:    state_nxt = ST_SAVE_CAUSE;
      ST_SAVE_CAUSE:  state_nxt = TVAL_EN ? ST_SAVE_TVAL : ST_SAVE_STATUS;
      ST_SAVE_TVAL:   state_nxt = ST_SAVE_STATUS;
      ST_SAVE_STATUS: state_nxt = ST_REDIRECT;
      ST_RESTORE:     state_nxt = ST_REDIRECT;
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default:        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_we    = 1'b0;
    csr_waddr = CSR_NONE;
    csr_wdata = 32'd0;
    case (state)
      ST_SAVE_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = ctx.epc & ~32'h3;
      end
      ST_SAVE_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = ctx.cause;
      end
      ST_SAVE_TVAL: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MTVAL;
        csr_wdata = ctx.tval;
      end
      ST_SAVE_STATUS: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mstatus_on_trap(csr_mstatus);
      end
      ST_RESTORE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mstatus_on_mret(csr_mstatus);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      ctx   <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        ctx.cause  <= sel_cause;
        ctx.epc    <= is_irq ? trap_npc : trap_pc;
        ctx.tval   <= is_exc ? trap_tval : 32'd0;
        ctx.target <= 32'd0;
        ctx.is_irq <= is_irq;
      end
      // Target CSRs are sampled late so a just-written mtvec/mepc is honoured.
      if (state == ST_SAVE_STATUS) begin
        ctx.target <= trap_vector(csr_mtvec, ctx.cause[4:0], VECTORED_EN & ctx.is_irq);
      end
      if (state == ST_RESTORE) begin
        ctx.target <= csr_mepc;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_trap_ctrl.sv
// Bench for the trap sequencer: vector table drives events, a scoreboard queue
// holds the expected CSR writes and redirect, and a negedge monitor checks them.
module tb_ysyx_24080006_trap_ctrl;
  import ysyx_24080006_pkg::*;

  logic        clock;
  logic        reset;
  logic        trap_valid;
  logic        trap_ready;
  logic [5:0]  trap_exc;
  logic        trap_mret;
  logic [31:0] trap_pc;
  logic [31:0] trap_npc;
  logic [31:0] trap_tval;
  logic        irq_ok;
  logic        irq_timer;
  logic [31:0] csr_mstatus;
  logic [31:0] csr_mie;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        csr_we;
  csr_name_e   csr_waddr;
  logic [31:0] csr_wdata;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;

  ysyx_24080006_trap_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .trap_valid     (trap_valid),
    .trap_ready     (trap_ready),
    .trap_exc       (trap_exc),
    .trap_mret      (trap_mret),
    .trap_pc        (trap_pc),
    .trap_npc       (trap_npc),
    .trap_tval      (trap_tval),
    .irq_ok         (irq_ok),
    .irq_timer      (irq_timer),
    .csr_mstatus    (csr_mstatus),
    .csr_mie        (csr_mie),
    .csr_mtvec      (csr_mtvec),
    .csr_mepc       (csr_mepc),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // kind: 0 = nothing taken, 1 = trap sequence, 2 = mret
  typedef struct {
    logic [5:0]  exc;
    logic        mret;
    logic        irq;
    logic        ok;
    logic [31:0] pc, npc, tval, ms, mie, mtvec, mepc;
    int          kind;
    logic [31:0] cause, epc, wtval, wms, rpc;
  } vec_t;

  typedef struct {
    logic        redir;
    csr_name_e   addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  vec_t vt[14];
  int   checks = 0;
  int   errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [5:0] exc, input logic mret, input logic irq,
                               input logic ok, input logic [31:0] pc, input logic [31:0] npc,
                               input logic [31:0] tval, input logic [31:0] ms,
                               input logic [31:0] mie, input logic [31:0] mtvec,
                               input logic [31:0] mepc, input int kind,
                               input logic [31:0] cause, input logic [31:0] epc,
                               input logic [31:0] wtval, input logic [31:0] wms,
                               input logic [31:0] rpc);
    vec_t v;
    v.exc = exc; v.mret = mret; v.irq = irq; v.ok = ok;
    v.pc = pc; v.npc = npc; v.tval = tval; v.ms = ms; v.mie = mie;
    v.mtvec = mtvec; v.mepc = mepc; v.kind = kind;
    v.cause = cause; v.epc = epc; v.wtval = wtval; v.wms = wms; v.rpc = rpc;
    return v;
  endfunction

  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset) begin
      if (csr_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_csr_write: got addr %0d data %h, expected no write",
                   csr_waddr, csr_wdata);
        end else begin
          e = exp_q.pop_front();
          chkb("sb_kind_csr", 1'b0, e.redir);
          chk32("sb_csr_addr", 32'(csr_waddr), 32'(e.addr));
          chk32("sb_csr_data", csr_wdata, e.data);
        end
      end
      if (redirect_valid && redirect_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_redirect: got pc %h, expected none", redirect_pc);
        end else begin
          e = exp_q.pop_front();
          chkb("sb_kind_redirect", 1'b1, e.redir);
          chk32("sb_redirect_pc", redirect_pc, e.data);
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic drive(input vec_t v, input int idx);
    trap_valid = 1'b1; trap_exc = v.exc; trap_mret = v.mret;
    irq_timer = v.irq; irq_ok = v.ok;
    trap_pc = v.pc; trap_npc = v.npc; trap_tval = v.tval;
    csr_mstatus = v.ms; csr_mie = v.mie; csr_mtvec = v.mtvec; csr_mepc = v.mepc;
    @(negedge clock);
    chkb($sformatf("v%0d_trap_ready", idx), trap_ready, 1'b1);
    if (v.kind != 0) chkb($sformatf("v%0d_flush", idx), flush, 1'b1);
    if (v.kind == 1) begin
      exp_q.push_back('{redir: 1'b0, addr: CSR_MEPC,    data: v.epc});
      exp_q.push_back('{redir: 1'b0, addr: CSR_MCAUSE,  data: v.cause});
      exp_q.push_back('{redir: 1'b0, addr: CSR_MTVAL,   data: v.wtval});
      exp_q.push_back('{redir: 1'b0, addr: CSR_MSTATUS, data: v.wms});
      exp_q.push_back('{redir: 1'b1, addr: CSR_NONE,    data: v.rpc});
    end else if (v.kind == 2) begin
      exp_q.push_back('{redir: 1'b0, addr: CSR_MSTATUS, data: v.wms});
      exp_q.push_back('{redir: 1'b1, addr: CSR_NONE,    data: v.rpc});
    end
    @(posedge clock);
    #1;
    trap_valid = 1'b0; trap_exc = '0; trap_mret = 1'b0; irq_timer = 1'b0;
  endtask

  // Returns on the falling edge where redirect_valid is first seen.
  task automatic wait_redirect(input int exp_lat, input int idx);
    int lat;
    lat = 1;
    @(negedge clock);
    chkb($sformatf("v%0d_flush_pulse_end", idx), flush, 1'b0);
    chkb($sformatf("v%0d_busy", idx), busy, 1'b1);
    while (!redirect_valid && lat < 20) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    chk32($sformatf("v%0d_latency", idx), lat, exp_lat);
  endtask

  task automatic finish_event(input int idx);
    @(posedge clock);
    #1;
    @(negedge clock);
    chkb($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
    chkb($sformatf("v%0d_idle_ready", idx), trap_ready, 1'b1);
    chk32($sformatf("v%0d_sb_drained", idx), exp_q.size(), 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    vt[0]  = mkv(6'b001000, 0, 0, 1, 32'h8000_0010, 32'h8000_0014, 32'h0, 32'h1808, 32'h0,
                 32'h8000_1000, 32'h0, 1, 32'd11, 32'h8000_0010, 32'h0, 32'h1880, 32'h8000_1000);
    vt[1]  = mkv(6'b001110, 0, 0, 1, 32'h8000_0040, 32'h8000_0044, 32'hFFFF_FFFF, 32'h1808, 32'h0,
                 32'h8000_1000, 32'h0, 1, 32'd2, 32'h8000_0040, 32'hFFFF_FFFF, 32'h1880, 32'h8000_1000);
    vt[2]  = mkv(6'b000000, 1, 0, 1, 32'h8000_0050, 32'h8000_0054, 32'h0, 32'h1880, 32'h0,
                 32'h8000_1000, 32'h8000_0014, 2, 32'h0, 32'h0, 32'h0, 32'h1888, 32'h8000_0014);
    vt[3]  = mkv(6'b000000, 0, 1, 1, 32'h8000_001C, 32'h8000_0020, 32'hDEAD_BEEF, 32'h1808, 32'h80,
                 32'h8000_1001, 32'h0, 1, 32'h8000_0007, 32'h8000_0020, 32'h0, 32'h1880, 32'h8000_101C);
    vt[4]  = mkv(6'b000000, 0, 1, 1, 32'h8000_001C, 32'h8000_0020, 32'h0, 32'h1800, 32'h80,
                 32'h8000_1001, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vt[5]  = mkv(6'b000000, 0, 1, 1, 32'h8000_001C, 32'h8000_0020, 32'h0, 32'h1808, 32'h08,
                 32'h8000_1001, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vt[6]  = mkv(6'b000000, 0, 1, 0, 32'h8000_001C, 32'h8000_0020, 32'h0, 32'h1808, 32'h80,
                 32'h8000_1001, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vt[7]  = mkv(6'b000000, 0, 1, 1, 32'h8000_0060, 32'h8000_0064, 32'h5, 32'h1808, 32'h80,
                 32'h8000_1000, 32'h0, 1, 32'h8000_0007, 32'h8000_0064, 32'h0, 32'h1880, 32'h8000_1000);
    vt[8]  = mkv(6'b110000, 0, 1, 1, 32'h8000_0100, 32'h8000_0104, 32'h1234_5679, 32'h1808, 32'h80,
                 32'h8000_1001, 32'h0, 1, 32'd4, 32'h8000_0100, 32'h1234_5679, 32'h1880, 32'h8000_1000);
    vt[9]  = mkv(6'b100000, 0, 0, 1, 32'h8000_0200, 32'h8000_0204, 32'h2000_0003, 32'h8000_0022, 32'h0,
                 32'h8000_3000, 32'h0, 1, 32'd6, 32'h8000_0200, 32'h2000_0003, 32'h8000_1822, 32'h8000_3000);
    vt[10] = mkv(6'b010001, 0, 0, 1, 32'h8000_0102, 32'h8000_0106, 32'h8000_0102, 32'h1808, 32'h0,
                 32'h8000_1000, 32'h0, 1, 32'd0, 32'h8000_0100, 32'h8000_0102, 32'h1880, 32'h8000_1000);
    vt[11] = mkv(6'b000000, 1, 1, 1, 32'h8000_0300, 32'h8000_0304, 32'h0, 32'h1808, 32'h80,
                 32'h8000_1001, 32'h8000_0200, 2, 32'h0, 32'h0, 32'h0, 32'h1880, 32'h8000_0200);
    vt[12] = mkv(6'b000010, 1, 0, 1, 32'h8000_0400, 32'h8000_0404, 32'h0000_0013, 32'h1800, 32'h0,
                 32'h8000_2000, 32'h8000_0500, 1, 32'd2, 32'h8000_0400, 32'h0000_0013, 32'h1800, 32'h8000_2000);
    vt[13] = mkv(6'b000000, 0, 0, 1, 32'h8000_0500, 32'h8000_0504, 32'h0, 32'h1808, 32'h80,
                 32'h8000_1001, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    reset = 1'b0; trap_valid = 1'b0; trap_exc = '0; trap_mret = 1'b0;
    trap_pc = '0; trap_npc = '0; trap_tval = '0; irq_ok = 1'b0; irq_timer = 1'b0;
    csr_mstatus = '0; csr_mie = '0; csr_mtvec = '0; csr_mepc = '0; redirect_ready = 1'b1;

    @(negedge clock);
    chkb("rst_trap_ready", trap_ready, 1'b1);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_csr_we", csr_we, 1'b0);
    chk32("rst_csr_waddr", 32'(csr_waddr), 32'd0);
    chk32("rst_csr_wdata", csr_wdata, 32'd0);
    chkb("rst_redirect_valid", redirect_valid, 1'b0);
    chk32("rst_redirect_pc", redirect_pc, 32'd0);
    chkb("rst_flush", flush, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 14; i++) begin
      drive(vt[i], i);
      if (vt[i].kind == 0) begin
        @(negedge clock);
        chkb($sformatf("v%0d_nop_busy", i), busy, 1'b0);
        chk32($sformatf("v%0d_nop_sb", i), exp_q.size(), 32'd0);
        @(posedge clock);
        #1;
      end else begin
        wait_redirect((vt[i].kind == 1) ? 5 : 2, i);
        finish_event(i);
      end
    end

    // Redirect held off for five cycles, taken on the sixth.
    redirect_ready = 1'b0;
    drive(vt[3], 100);
    wait_redirect(5, 100);
    for (int i = 0; i < 5; i++) begin
      chkb($sformatf("bp%0d_valid", i), redirect_valid, 1'b1);
      chk32($sformatf("bp%0d_pc", i), redirect_pc, 32'h8000_101C);
      chkb($sformatf("bp%0d_busy", i), busy, 1'b1);
      chkb($sformatf("bp%0d_trap_ready", i), trap_ready, 1'b0);
      @(posedge clock);
      #1;
      if (i < 4) @(negedge clock);
    end
    redirect_ready = 1'b1;
    @(negedge clock);
    chkb("bp_valid_at_accept", redirect_valid, 1'b1);
    finish_event(100);

    // Asynchronous reset while mcause is being written.
    drive(vt[0], 200);
    n = 0;
    @(negedge clock);
    while (!(csr_we && csr_waddr == CSR_MCAUSE) && n < 10) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
    chkb("mid_reached_save_cause", (n < 10), 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chkb("mid_rst_csr_we", csr_we, 1'b0);
    chk32("mid_rst_csr_wdata", csr_wdata, 32'd0);
    chkb("mid_rst_busy", busy, 1'b0);
    chkb("mid_rst_redirect_valid", redirect_valid, 1'b0);
    chkb("mid_rst_trap_ready", trap_ready, 1'b1);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chkb("post_rst_trap_ready", trap_ready, 1'b1);
    chkb("post_rst_busy", busy, 1'b0);
    @(posedge clock);
    #1;
    drive(vt[2], 201);
    wait_redirect(2, 201);
    finish_event(201);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
